// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector: per-channel synchroniser, debounce filter,
// mode-selected single-cycle edge pulses and write-one-to-clear sticky flags.
module edge_detector_multi #(
    parameter int N_CH          = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] signal,
    input  logic [1:0]      mode,
    input  logic [N_CH-1:0] clear,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] edge_pulse,
    output logic [N_CH-1:0] event_sticky,
    output logic            irq
);

    localparam int F  = (FILTER_CYCLES < 1) ? 1 : FILTER_CYCLES;
    localparam int CW = $clog2(F + 1);
    localparam logic [CW-1:0] F_LAST = CW'(F - 1);

    logic [N_CH-1:0] synced;
    logic [N_CH-1:0] accept;
    logic [N_CH-1:0] pulse_next;
    logic [CW-1:0]   cnt [N_CH];

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign synced = signal;
        end else begin : g_sync
            logic [N_CH-1:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
                end else begin
                    sync_q[0] <= signal;
                    for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
                end
            end

            assign synced = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // A channel flips on the edge where its counter has already seen F-1 differing cycles.
    always_comb begin
        accept = '0;
        for (int i = 0; i < N_CH; i++) begin
            accept[i] = (synced[i] != level[i]) && (cnt[i] == F_LAST);
        end
        pulse_next = (accept & synced & {N_CH{mode[0]}}) |
                     (accept & ~synced & {N_CH{mode[1]}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
            level        <= '0;
            edge_pulse   <= '0;
            event_sticky <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (synced[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == F_LAST) begin
                    cnt[i]   <= '0;
                    level[i] <= synced[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
            edge_pulse   <= pulse_next;
            // A new event beats a coincident clear.
            event_sticky <= (event_sticky & ~clear) | pulse_next;
        end
    end

    assign irq = |event_sticky;

endmodule

// File: tb/tb_edge_detector_multi.sv
// Directed bench for edge_detector_multi: default instance plus a
// SYNC_STAGES=0 / FILTER_CYCLES=0 / N_CH=1 instance sharing clock and reset.
module tb_edge_detector_multi;

  logic       clk;
  logic       rst;
  logic [7:0] signal;
  logic [1:0] mode;
  logic [7:0] clear;
  logic [7:0] level;
  logic [7:0] edge_pulse;
  logic [7:0] event_sticky;
  logic       irq;

  logic [0:0] sig_s;
  logic [0:0] clear_s;
  logic [0:0] level_s;
  logic [0:0] pulse_s;
  logic [0:0] sticky_s;
  logic       irq_s;

  int n_cmp;
  int n_fail;

  edge_detector_multi #(.N_CH(8), .SYNC_STAGES(2), .FILTER_CYCLES(4)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .signal       (signal),
    .mode         (mode),
    .clear        (clear),
    .level        (level),
    .edge_pulse   (edge_pulse),
    .event_sticky (event_sticky),
    .irq          (irq)
  );

  edge_detector_multi #(.N_CH(1), .SYNC_STAGES(0), .FILTER_CYCLES(0)) u_small (
    .clk          (clk),
    .rst          (rst),
    .signal       (sig_s),
    .mode         (mode),
    .clear        (clear_s),
    .level        (level_s),
    .edge_pulse   (pulse_s),
    .event_sticky (sticky_s),
    .irq          (irq_s)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_all();
    clear = 8'hFF;
    tick();
    clear = 8'h00;
  endtask

  // Hold sig for 10 edges; edge_pulse must equal exp6 on the 6th edge and 0 otherwise.
  task automatic phase(input string tag, input logic [7:0] sig, input logic [7:0] exp6);
    signal = sig;
    for (int t = 1; t <= 10; t++) begin
      tick();
      check(tag, edge_pulse, (t == 6) ? exp6 : 8'h00);
    end
    check({tag, "_level"}, level, sig);
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    rst     = 1'b1;
    signal  = 8'hFF;
    mode    = 2'b01;
    clear   = 8'h00;
    sig_s   = 1'b0;
    clear_s = 1'b0;

    // Reset / idle with inputs held high through reset
    repeat (3) tick();
    check("rst_level", level, 8'h00);
    check("rst_pulse", edge_pulse, 8'h00);
    check("rst_sticky", event_sticky, 8'h00);
    check("rst_irq", 8'(irq), 8'h00);
    check("rst_small_level", 8'(level_s), 8'h00);
    rst = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      tick();
      check("lat_level", level, 8'h00);
      check("lat_pulse", edge_pulse, 8'h00);
      check("lat_sticky", event_sticky, 8'h00);
    end
    tick();
    check("edge6_level", level, 8'hFF);
    check("edge6_pulse", edge_pulse, 8'hFF);
    check("edge6_sticky", event_sticky, 8'hFF);
    check("edge6_irq", 8'(irq), 8'h01);
    tick();
    check("edge7_pulse", edge_pulse, 8'h00);
    check("edge7_sticky", event_sticky, 8'hFF);
    clear_all();
    check("clr_sticky", event_sticky, 8'h00);
    check("clr_irq", 8'(irq), 8'h00);

    // Drop all channels; falls are not reported under mode 01
    phase("fall_m01", 8'h00, 8'h00);
    check("fall_m01_sticky", event_sticky, 8'h00);

    // Debounce: a 3-cycle blip on ch0 is rejected
    signal = 8'h01;
    repeat (3) tick();
    signal = 8'h00;
    for (int t = 1; t <= 10; t++) begin
      tick();
      check("glitch_pulse", edge_pulse, 8'h00);
      check("glitch_level", level, 8'h00);
    end
    phase("deb_hold", 8'h01, 8'h01);
    check("deb_sticky", event_sticky, 8'h01);
    clear_all();

    // Modes on ch2, ch0 held high throughout
    mode = 2'b01;
    phase("m01_rise", 8'h05, 8'h04);
    phase("m01_fall", 8'h01, 8'h00);
    check("m01_sticky", event_sticky, 8'h04);
    clear_all();
    mode = 2'b10;
    phase("m10_rise", 8'h05, 8'h00);
    phase("m10_fall", 8'h01, 8'h04);
    check("m10_sticky", event_sticky, 8'h04);
    clear_all();
    mode = 2'b11;
    phase("m11_rise", 8'h05, 8'h04);
    phase("m11_fall", 8'h01, 8'h04);
    check("m11_sticky", event_sticky, 8'h04);
    clear_all();
    mode = 2'b00;
    phase("m00_rise", 8'h05, 8'h00);
    phase("m00_fall", 8'h01, 8'h00);
    check("m00_sticky", event_sticky, 8'h00);
    check("m00_irq", 8'(irq), 8'h00);

    // Sticky race on ch3: clear coincides with the pulse edge
    mode   = 2'b01;
    signal = 8'h09;
    repeat (5) tick();
    clear = 8'h08;
    tick();
    check("race_pulse", edge_pulse, 8'h08);
    check("race_sticky", event_sticky, 8'h08);
    check("race_irq", 8'(irq), 8'h01);
    clear = 8'h00;
    tick();
    check("race_hold", event_sticky, 8'h08);
    clear = 8'h08;
    tick();
    check("race_clear", event_sticky, 8'h00);
    check("race_irq_drop", 8'(irq), 8'h00);
    tick();
    check("race_clear_again", event_sticky, 8'h00);
    clear = 8'h00;

    // Reset while ch1 is mid-filter (count 2 of 4)
    signal = 8'h0B;
    repeat (4) tick();
    check("mid_level", level, 8'h09);
    rst = 1'b1;
    tick();
    check("mid_rst_level", level, 8'h00);
    check("mid_rst_sticky", event_sticky, 8'h00);
    rst = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      tick();
      check("mid_lat_level", level, 8'h00);
      check("mid_lat_pulse", edge_pulse, 8'h00);
    end
    tick();
    check("mid_edge6_level", level, 8'h0B);
    check("mid_edge6_pulse", edge_pulse, 8'h0B);

    // No synchroniser, no filter: every single-cycle toggle is an edge
    mode  = 2'b11;
    sig_s = 1'b1;
    tick();
    check("small_rise_level", 8'(level_s), 8'h01);
    check("small_rise_pulse", 8'(pulse_s), 8'h01);
    for (int t = 0; t < 6; t++) begin
      sig_s = ~sig_s;
      tick();
      check("small_tog_level", 8'(level_s), 8'(sig_s));
      check("small_tog_pulse", 8'(pulse_s), 8'h01);
    end
    tick();
    check("small_idle_pulse", 8'(pulse_s), 8'h00);
    check("small_sticky", 8'(sticky_s), 8'h01);
    check("small_irq", 8'(irq_s), 8'h01);
    clear_s = 1'b1;
    tick();
    clear_s = 1'b0;
    check("small_clear", 8'(sticky_s), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
